// File: rtl/gpio_ctrl.sv
// gpio_ctrl - memory-mapped GPIO peripheral.
//
// Each pin has an output register and a direction register. Inputs pass
// through a 2-flop synchronizer. Rising edges are captured in sticky EDGE bits
// that are cleared by writing 1s (W1C), and irq is a level interrupt.
// Read data is registered, so a read has one cycle of latency.
//
// Register map (word offset = gpio_addr[4:2]):
//   0 OUT (RW)   1 DIR (RW)   2 IN (RO)   3 EDGE (R/W1C)   4 IRQ_EN (RW)
//   5 OUT_SET (WO)   6 OUT_CLR (WO)   7 reserved
//   Write-only and reserved offsets read as 0. Bits at or above N_GPIO read as 0.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   gpio_we             write strobe, already qualified by the GPIO select
//   gpio_addr           byte address; only bits [4:2] are decoded
//   gpio_wdata          write data
//   gpio_rdata          registered read data
//   pin_in              asynchronous pad inputs
//   pin_out, pin_oe     pad output values and output enables (1 = drive)
//   irq                 |(EDGE & IRQ_EN)
//
// Optional feature: define GPIO_DEBOUNCE_EN to add a per-pin debounce stage.
// A synchronized input is accepted only after it has differed from the
// accepted value for DEBOUNCE_CYCLES consecutive cycles.

module gpio_ctrl #(
   parameter int unsigned N_GPIO          = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              gpio_we,
   input  logic [31:0]       gpio_addr,
   input  logic [31:0]       gpio_wdata,
   output logic [31:0]       gpio_rdata,
   input  logic [N_GPIO-1:0] pin_in,
   output logic [N_GPIO-1:0] pin_out,
   output logic [N_GPIO-1:0] pin_oe,
   output logic              irq
);

   typedef enum logic [2:0] {
      OFF_OUT     = 3'd0,
      OFF_DIR     = 3'd1,
      OFF_IN      = 3'd2,
      OFF_EDGE    = 3'd3,
      OFF_IRQ_EN  = 3'd4,
      OFF_OUT_SET = 3'd5,
      OFF_OUT_CLR = 3'd6,
      OFF_RSVD    = 3'd7
   } reg_off_e;

   if (N_GPIO < 1 || N_GPIO > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("gpio_ctrl: N_GPIO must be 1..32 and DEBOUNCE_CYCLES >= 1");
   end

   reg_off_e          off;
   logic [N_GPIO-1:0] wd;
   logic [N_GPIO-1:0] out_q;
   logic [N_GPIO-1:0] dir_q;
   logic [N_GPIO-1:0] edge_q;
   logic [N_GPIO-1:0] irq_en_q;
   logic [N_GPIO-1:0] sync1_q;
   logic [N_GPIO-1:0] sync2_q;
   logic [N_GPIO-1:0] prev_q;
   logic [N_GPIO-1:0] acc;
   logic [N_GPIO-1:0] edge_clr;
   logic [N_GPIO-1:0] edge_set;
   logic [31:0]       rd_mux;
   logic              unused_bits;

   assign off         = reg_off_e'(gpio_addr[4:2]);
   assign wd          = gpio_wdata[N_GPIO-1:0];
   assign unused_bits = ^{gpio_addr[31:5], gpio_addr[1:0], gpio_wdata};

   // Input synchronizer and the previous-accepted-value flop used for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= pin_in;
         sync2_q <= sync1_q;
         prev_q  <= acc;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0]     cnt_q [N_GPIO];
   logic [N_GPIO-1:0] acc_q;

   // The counter tracks how long sync2 has disagreed with the accepted value.
   // The new value is taken on the DEBOUNCE_CYCLES-th consecutive mismatch.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         for (int unsigned i = 0; i < N_GPIO; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_GPIO; i++) begin
            if (sync2_q[i] != acc_q[i]) begin
               if (cnt_q[i] == CNT_LAST) begin
                  acc_q[i] <= sync2_q[i];
                  cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + CW'(1);
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign acc = acc_q;
`else
   assign acc = sync2_q;
`endif

   // A rising edge detected in the same cycle as a W1C of that bit keeps the bit set.
   assign edge_clr = (gpio_we && off == OFF_EDGE) ? wd : '0;
   assign edge_set = acc & ~prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q    <= '0;
         dir_q    <= '0;
         irq_en_q <= '0;
         edge_q   <= '0;
      end else begin
         edge_q <= (edge_q & ~edge_clr) | edge_set;
         if (gpio_we) begin
            case (off)
               OFF_OUT:     out_q    <= wd;
               OFF_DIR:     dir_q    <= wd;
               OFF_IRQ_EN:  irq_en_q <= wd;
               OFF_OUT_SET: out_q    <= out_q | wd;
               OFF_OUT_CLR: out_q    <= out_q & ~wd;
               default:     ;
            endcase
         end
      end
   end

   // The read mux sees the pre-write register values, so a read and a write
   // to the same address in one cycle return the old contents.
   always_comb begin
      rd_mux = '0;
      case (off)
         OFF_OUT:    rd_mux[N_GPIO-1:0] = out_q;
         OFF_DIR:    rd_mux[N_GPIO-1:0] = dir_q;
         OFF_IN:     rd_mux[N_GPIO-1:0] = acc;
         OFF_EDGE:   rd_mux[N_GPIO-1:0] = edge_q;
         OFF_IRQ_EN: rd_mux[N_GPIO-1:0] = irq_en_q;
         default:    ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_rdata <= '0;
      end else begin
         gpio_rdata <= rd_mux;
      end
   end

   assign pin_out = out_q;
   assign pin_oe  = dir_q;
   assign irq     = |(edge_q & irq_en_q);

endmodule
